synapse_code_server: RTL and testbench
======================================

// Module: synapse_code_server
// PURPOSE
//  Code-memory responder for the synapse316 fetch port. It serves code_in/code_ready for the
//  core's code_addr from a 2-word buffer, and refills that buffer from a slow byte-wide backing
//  memory (flash/SRAM bridge). The core is unchanged: it only sees code_ready deassert on misses.
//  Sequential code streams without stalls once the buffer's prefetch has caught up.
// PARAMETERS
//  IPR_WIDTH   16   word-address width; must equal the core's IPR_WIDTH
// PORTS
//  sysclk       in   1            system clock, posedge
//  sysreset_n   in   1            asynchronous reset, active-low
//  code_addr    in   IPR_WIDTH    word address from the core, combinational, may change every cycle
//  code_in      out  16           instruction/data word for code_addr; 16'h0000 when !code_ready
//  code_ready   out  1            code_in is valid for the current code_addr (combinational)
//  flush        in   1            1-cycle pulse: invalidate both buffer slots
//  mem_addr     out  IPR_WIDTH+1  byte address to backing memory; word w -> bytes {w,0}=lo, {w,1}=hi
//  mem_rd       out  1            read request; held high, mem_addr stable, until mem_valid
//  mem_data     in   8            read byte, sampled when mem_valid
//  mem_valid    in   1            1-cycle pulse, earliest the cycle after mem_rd rises
//  fetch_busy   out  1            FSM not IDLE (debug visibility)
// BEHAVIOUR
//  - Slots S0,S1: {valid, tag[IPR_WIDTH-1:0], data[15:0]}.
//  - Hit: slot valid && tag==code_addr. code_ready = hit in either slot; code_in = data of the
//    hit slot, with S0 taking priority; 0 when there is no hit.
//  - Reset (async, any state): valid bits=0, state=IDLE, mem_rd=0, mem_addr=0, code_ready=0,
//    code_in=0, fetch_busy=0. Reset mid-transfer drops mem_rd at once; the partial byte is discarded.
//  - FSM IDLE/LO/HI.
//    IDLE, miss: demand fetch. target<=code_addr, victim<=S0, kind<=DEMAND, next state LO.
//    IDLE, hit, code_addr+1 in neither slot: prefetch. target<=code_addr+1, modulo 2^IPR_WIDTH
//      (max wraps to 0). victim<=the slot that did not hit. kind<=PREFETCH. Next state LO.
//    IDLE, otherwise: stay in IDLE.
//    LO: mem_rd=1, mem_addr={target,1'b0}. On mem_valid, lo<=mem_data and go to HI.
//    HI: mem_rd=1, mem_addr={target,1'b1}. On mem_valid, victim<={1,target,{mem_data,lo}}, go IDLE.
//  - Prefetch abort: in LO/HI with kind=PREFETCH, code_addr is a miss on the mem_valid cycle ->
//    the byte is accepted but the transfer ends. Go to IDLE with no slot write. The demand fetch
//    starts from IDLE on the next cycle. A bus transaction is never abandoned before mem_valid.
//  - A DEMAND fetch always completes and writes its slot, even if code_addr has moved away.
//  - flush: clears both valid bits that cycle. If a fetch is in flight, it finishes its bus
//    transactions but does not write its slot. flush coincident with the HI mem_valid: flush
//    wins, and the slot stays invalid.
//  - mem_valid while mem_rd=0 is ignored.
//  - Latency: zero-wait memory (mem_valid the cycle after mem_rd) gives a miss in cycle 0 and
//    code_ready in cycle 5. Each memory wait cycle adds 1 per byte.
//  - Sequential hit with prefetch complete: 0 stall cycles.
//  - No tag check on writes: a later fetch of the same address simply overwrites.
// TESTING
//  1 Reset mid-HI with mem_rd=1 -> same cycle mem_rd=0, code_ready=0, code_in=0. After release,
//    the next miss refetches from the lo byte.
//  2 Cold miss, mem[0]=8'h34, mem[1]=8'h12, zero-wait, code_addr=0 -> code_ready=1 and
//    code_in=16'h1234 in cycle 5. Then mem_addr=0x0002 prefetch starts.
//  3 Hold code_addr=0 until fetch_busy=0, then step to 1 (mem[2..3]=CD,AB) -> code_ready=1 that
//    cycle, code_in=16'hABCD. Prefetch of word 2 then goes into S0.
//  4 Prefetch of word 2 in LO, code_addr jumps to 16'h0100 -> byte 0x0004 completes and no slot
//    is written. mem_addr=0x0200 follows, and code_ready rises 5 cycles after the jump completes.
//  5 code_addr=16'hFFFF, hit -> prefetch target 0, mem_addr 17'h00000, then 17'h00001.
//  6 flush coincident with HI mem_valid of a demand fetch -> code_ready stays 0, and a new LO
//    fetch of the same address follows.

Source files
------------

// File: rtl/synapse_code_server.sv
// Two-slot code buffer for the synapse316 fetch port, refilled byte-wise from a slow backing memory.
// Misses trigger a demand fetch; hits trigger a prefetch of the next sequential word.
module synapse_code_server #(
    parameter int IPR_WIDTH = 16
) (
    input  logic                 sysclk,
    input  logic                 sysreset_n,
    input  logic [IPR_WIDTH-1:0] code_addr,
    output logic [15:0]          code_in,
    output logic                 code_ready,
    input  logic                 flush,
    output logic [IPR_WIDTH:0]   mem_addr,
    output logic                 mem_rd,
    input  logic [7:0]           mem_data,
    input  logic                 mem_valid,
    output logic                 fetch_busy
);

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    state_t                         state_q, state_d;
    logic [IPR_WIDTH-1:0]           target_q, target_d;
    logic                           victim_q, victim_d;
    logic                           pref_q, pref_d;
    logic                           drop_q, drop_d;
    logic [7:0]                     lo_q, lo_d;
    logic [1:0]                     valid_q, valid_d;
    logic [1:0][IPR_WIDTH-1:0]      tag_q, tag_d;
    logic [1:0][15:0]               data_q, data_d;

    logic                 hit0, hit1, nxt_hit, abort;
    logic [IPR_WIDTH-1:0] nxt_addr;

    assign hit0       = valid_q[0] && (tag_q[0] == code_addr);
    assign hit1       = valid_q[1] && (tag_q[1] == code_addr);
    assign code_ready = hit0 || hit1;
    assign code_in    = hit0 ? data_q[0] : (hit1 ? data_q[1] : 16'h0000);
    assign fetch_busy = (state_q != IDLE);

    // Wraps naturally at 2^IPR_WIDTH.
    assign nxt_addr = code_addr + {{(IPR_WIDTH-1){1'b0}}, 1'b1};
    assign nxt_hit  = (valid_q[0] && (tag_q[0] == nxt_addr)) ||
                      (valid_q[1] && (tag_q[1] == nxt_addr));
    // A prefetch yields to a demand miss, but only once the current byte has landed.
    assign abort    = pref_q && !code_ready;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        victim_d = victim_q;
        pref_d   = pref_q;
        drop_d   = drop_q;
        lo_d     = lo_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;
        mem_rd   = 1'b0;
        mem_addr = '0;

        if (flush) begin
            valid_d = 2'b00;
            if (state_q != IDLE) drop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (!code_ready) begin
                    target_d = code_addr;
                    victim_d = 1'b0;
                    pref_d   = 1'b0;
                    state_d  = LO;
                end else if (!nxt_hit) begin
                    target_d = nxt_addr;
                    victim_d = hit0;
                    pref_d   = 1'b1;
                    state_d  = LO;
                end
            end
            LO: begin
                mem_rd   = 1'b1;
                mem_addr = {target_q, 1'b0};
                if (mem_valid) begin
                    lo_d    = mem_data;
                    state_d = abort ? IDLE : HI;
                end
            end
            HI: begin
                mem_rd   = 1'b1;
                mem_addr = {target_q, 1'b1};
                if (mem_valid) begin
                    state_d = IDLE;
                    if (!abort && !drop_q && !flush) begin
                        valid_d[victim_q] = 1'b1;
                        tag_d[victim_q]   = target_q;
                        data_d[victim_q]  = {mem_data, lo_q};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            victim_q <= 1'b0;
            pref_q   <= 1'b0;
            drop_q   <= 1'b0;
            lo_q     <= '0;
            valid_q  <= '0;
            tag_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            victim_q <= victim_d;
            pref_q   <= pref_d;
            drop_q   <= drop_d;
            lo_q     <= lo_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_synapse_code_server.sv
// Bench for synapse_code_server: zero-wait byte memory model with a bus-address scoreboard,
// plus cycle-checked fetch-port results for cold miss, prefetch, abort, wrap, flush and reset.
module tb_synapse_code_server;

    logic        sysclk = 1'b0;
    logic        sysreset_n;
    logic [15:0] code_addr;
    logic [15:0] code_in;
    logic        code_ready;
    logic        flush;
    logic [16:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic        fetch_busy;

    int n_vec = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];

    synapse_code_server #(.IPR_WIDTH(16)) dut (
        .sysclk     (sysclk),
        .sysreset_n (sysreset_n),
        .code_addr  (code_addr),
        .code_in    (code_in),
        .code_ready (code_ready),
        .flush      (flush),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_valid  (mem_valid),
        .fetch_busy (fetch_busy)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [16:0] a);
        case (a)
            17'h0: return 8'h34;
            17'h1: return 8'h12;
            17'h2: return 8'hCD;
            17'h3: return 8'hAB;
            default: return a[7:0] ^ a[15:8] ^ {a[16], 7'h2A};
        endcase
    endfunction

    function automatic logic [15:0] word_of(input logic [15:0] w);
        return {byte_of({w, 1'b1}), byte_of({w, 1'b0})};
    endfunction

    // Zero-wait memory: answers the cycle after each new request; every request is scoreboarded.
    always @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            mem_valid <= 1'b0;
            mem_data  <= 8'h00;
        end else if (mem_rd && !mem_valid) begin
            chk("bus_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("bus_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
            mem_valid <= 1'b1;
            mem_data  <= byte_of(mem_addr);
        end else begin
            mem_valid <= 1'b0;
        end
    end

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sysclk);
            if (!fetch_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        bit ok;
        sysreset_n = 1'b0;
        code_addr  = 16'h0000;
        flush      = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        chk("rst_ready", 32'(code_ready), 32'd0);
        chk("rst_code", 32'(code_in), 32'd0);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_maddr", 32'(mem_addr), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);

        // Cold miss on word 0, then sequential prefetch of word 1.
        exp_q.push_back(17'h0); exp_q.push_back(17'h1);
        exp_q.push_back(17'h2); exp_q.push_back(17'h3);
        @(posedge sysclk); #1;
        sysreset_n = 1'b1;
        @(negedge sysclk);
        chk("cold_c0_ready", 32'(code_ready), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge sysclk);
            chk("cold_ready", 32'(code_ready), 32'(k >= 5));
            if (k == 1) begin
                chk("cold_lo_rd", 32'(mem_rd), 32'd1);
                chk("cold_lo_addr", 32'(mem_addr), 32'h0);
            end
            if (k == 5) chk("cold_data", 32'(code_in), 32'h1234);
            if (k == 6) chk("pref1_addr", 32'(mem_addr), 32'h2);
        end
        wait_idle("pref1_idle");

        // Step to word 1: prefetched, no stall; prefetch of word 2 starts and is aborted.
        code_addr = 16'h0001;
        exp_q.push_back(17'h4);
        #1;
        chk("seq_ready", 32'(code_ready), 32'd1);
        chk("seq_data", 32'(code_in), 32'hABCD);
        @(negedge sysclk);
        chk("pref2_rd", 32'(mem_rd), 32'd1);
        chk("pref2_addr", 32'(mem_addr), 32'h4);
        code_addr = 16'h0100;
        exp_q.push_back(17'h200); exp_q.push_back(17'h201);
        exp_q.push_back(17'h202); exp_q.push_back(17'h203);
        @(negedge sysclk);
        @(negedge sysclk);
        chk("abort_busy", 32'(fetch_busy), 32'd0);
        chk("abort_ready", 32'(code_ready), 32'd0);
        for (int k = 3; k <= 7; k++) begin
            @(negedge sysclk);
            if (k == 3) chk("jump_addr", 32'(mem_addr), 32'h200);
            chk("jump_ready", 32'(code_ready), 32'(k == 7));
        end
        chk("jump_data", 32'(code_in), 32'(word_of(16'h0100)));
        wait_idle("jump_idle");

        // Top of address space: prefetch target wraps to word 0.
        code_addr = 16'hFFFF;
        exp_q.push_back(17'h1FFFE); exp_q.push_back(17'h1FFFF);
        exp_q.push_back(17'h0);     exp_q.push_back(17'h1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge sysclk);
            if (k == 5) begin
                chk("wrap_ready", 32'(code_ready), 32'd1);
                chk("wrap_data", 32'(code_in), 32'(word_of(16'hFFFF)));
            end
            if (k == 6) chk("wrap_lo_addr", 32'(mem_addr), 32'h0);
            if (k == 8) chk("wrap_hi_addr", 32'(mem_addr), 32'h1);
        end
        wait_idle("wrap_idle");
        code_addr = 16'h0000;
        exp_q.push_back(17'h2); exp_q.push_back(17'h3);
        #1;
        chk("wrap_hit_ready", 32'(code_ready), 32'd1);
        chk("wrap_hit_data", 32'(code_in), 32'h1234);
        wait_idle("wrap2_idle");

        // Flush on the final byte of a demand fetch: no write, refetch follows.
        code_addr = 16'h0300;
        exp_q.push_back(17'h600); exp_q.push_back(17'h601);
        exp_q.push_back(17'h600); exp_q.push_back(17'h601);
        exp_q.push_back(17'h602); exp_q.push_back(17'h603);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            if (mem_valid && mem_rd && mem_addr == 17'h601) begin
                ok = 1'b1;
                break;
            end
        end
        chk("flush_hi_seen", 32'(ok), 32'd1);
        flush = 1'b1;
        @(posedge sysclk); #1;
        flush = 1'b0;
        @(negedge sysclk);
        chk("flush_ready", 32'(code_ready), 32'd0);
        chk("flush_busy", 32'(fetch_busy), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge sysclk);
            if (k == 1) chk("reflt_addr", 32'(mem_addr), 32'h600);
            chk("reflt_ready", 32'(code_ready), 32'(k == 5));
        end
        chk("reflt_data", 32'(code_in), 32'(word_of(16'h0300)));
        wait_idle("flush_idle");

        // Reset in the middle of the hi byte transfer.
        code_addr = 16'h0400;
        exp_q.push_back(17'h800);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            if (mem_rd && !mem_valid && mem_addr == 17'h801) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_hi_seen", 32'(ok), 32'd1);
        code_addr = 16'h0300;
        #1;
        chk("pre_rst_ready", 32'(code_ready), 32'd1);
        sysreset_n = 1'b0;
        #1;
        chk("mid_rst_rd", 32'(mem_rd), 32'd0);
        chk("mid_rst_ready", 32'(code_ready), 32'd0);
        chk("mid_rst_code", 32'(code_in), 32'd0);
        chk("mid_rst_busy", 32'(fetch_busy), 32'd0);
        code_addr = 16'h0400;
        exp_q.push_back(17'h800); exp_q.push_back(17'h801);
        exp_q.push_back(17'h802); exp_q.push_back(17'h803);
        repeat (2) @(posedge sysclk);
        #1;
        sysreset_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            if (code_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("post_rst_ready", 32'(ok), 32'd1);
        chk("post_rst_data", 32'(code_in), 32'(word_of(16'h0400)));
        wait_idle("post_rst_idle");
        chk("bus_q_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
